// File: rtl/imem_loader_if.sv
// Byte-stream source and instruction-memory write bus of the program loader.
// Also carries the loader's status outputs and the core reset hold.
interface imem_loader_if #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
);
    logic                   i_start;
    logic [7:0]             i_len;
    logic                   i_byte_valid;
    logic [7:0]             i_byte_data;
    logic                   o_byte_ready;
    logic [INS_ADDRESS-1:0] o_wa;
    logic [INS_W-1:0]       o_wd;
    logic                   o_we;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_err;
    logic                   o_core_rst_n;

    modport slave (
        input  i_start, i_len, i_byte_valid, i_byte_data,
        output o_byte_ready, o_wa, o_wd, o_we, o_busy, o_done, o_err, o_core_rst_n
    );

    modport master (
        output i_start, i_len, i_byte_valid, i_byte_data,
        input  o_byte_ready, o_wa, o_wd, o_we, o_busy, o_done, o_err, o_core_rst_n
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles little-endian program bytes into 32-bit words and writes them to
// instruction memory while holding the RISC-V core in reset.
//
// state | meaning
// IDLE  | waiting for start; err reports the last rejected start
// RECV  | collecting the 4 bytes of the current word
// WRITE | one-cycle write of the assembled word
// DONE  | load finished; done held until the next accepted start
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    imem_loader_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(2 ** (INS_ADDRESS - 2));

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_start_ok;
    logic                   w_start_bad;
    logic                   w_len_ok;
    logic                   w_byte_acc;
    logic                   w_last_word;
    logic [INS_ADDRESS-1:0] w_wa;

    logic [7:0]             r_len;
    logic [7:0]             r_word_idx;
    logic [1:0]             r_byte_idx;
    logic [INS_W-9:0]       r_buf;
    logic                   r_byte_ready;
    logic [INS_ADDRESS-1:0] r_wa;
    logic [INS_W-1:0]       r_wd;
    logic                   r_we;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;
    logic                   r_core_rst_n;

    assign w_len_ok    = (bus.i_len != 8'd0) && ({24'd0, bus.i_len} <= MAX_WORDS);
    assign w_byte_acc  = r_byte_ready && bus.i_byte_valid;
    assign w_last_word = (r_word_idx == (r_len - 8'd1));
    assign w_wa        = INS_ADDRESS'({r_word_idx, 2'b00});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_bad = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.i_start) begin
                    if (w_len_ok) begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_RECV;
                    end else begin
                        w_start_bad = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RECV: begin
                if (w_byte_acc && (r_byte_idx == 2'd3)) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = w_last_word ? ST_DONE : ST_RECV;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_buf        <= '0;
            r_byte_ready <= 1'b0;
            r_wa         <= '0;
            r_wd         <= '0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_byte_ready <= (w_state_nxt == ST_RECV);
            r_we         <= (w_state_nxt == ST_WRITE);
            r_busy       <= (w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE);
            r_core_rst_n <= !((w_state_nxt == ST_RECV) || (w_state_nxt == ST_WRITE));
            r_done       <= (w_state_nxt == ST_DONE);

            if (w_start_ok) begin
                r_len      <= bus.i_len;
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_err      <= 1'b0;
            end else if (w_start_bad) begin
                r_err <= 1'b1;
            end

            if (w_byte_acc) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                case (r_byte_idx)
                    2'd0: r_buf[7:0]   <= bus.i_byte_data;
                    2'd1: r_buf[15:8]  <= bus.i_byte_data;
                    2'd2: r_buf[23:16] <= bus.i_byte_data;
                    default: begin
                        r_wd <= {bus.i_byte_data, r_buf};
                        r_wa <= w_wa;
                    end
                endcase
            end

            if ((r_state == ST_WRITE) && !w_last_word) begin
                r_word_idx <= r_word_idx + 8'd1;
            end
        end
    end

    assign bus.o_byte_ready = r_byte_ready;
    assign bus.o_wa         = r_wa;
    assign bus.o_wd         = r_wd;
    assign bus.o_we         = r_we;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_err        = r_err;
    assign bus.o_core_rst_n = r_core_rst_n;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as words are
// driven and checked against every observed write strobe.
module tb_imem_loader;
    localparam int INS_ADDRESS = 9;

    typedef struct packed {
        logic [INS_ADDRESS-1:0] wa;
        logic [31:0]            wd;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int w0;
    logic [31:0] word;

    wr_t exp_q[$];
    logic [INS_ADDRESS-1:0] last_wa = '0;
    logic [31:0]            last_wd = '0;

    imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(32)) bus ();

    imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(32)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (bus.o_we === 1'b1) begin
            n_writes++;
            chk("we_expected", 64'(exp_q.size() > 0), 64'd1);
            chk("ready_low_in_write", 64'(bus.o_byte_ready), 64'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wa", 64'(bus.o_wa), 64'(e.wa));
                chk("wd", 64'(bus.o_wd), 64'(e.wd));
                last_wa = e.wa;
                last_wd = e.wd;
            end
        end else begin
            chk("wa_hold", 64'(bus.o_wa), 64'(last_wa));
            chk("wd_hold", 64'(bus.o_wd), 64'(last_wd));
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int   n;
        logic rdy;
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                bus.i_byte_valid = 1'b0;
                tick();
            end
        end
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data  = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            rdy = bus.o_byte_ready;
            tick();
            n++;
        end
        chk("byte_accepted", 64'(rdy), 64'd1);
    endtask

    task automatic load_word(input int idx, input logic [31:0] w, input bit stall);
        wr_t e;
        e.wa = INS_ADDRESS'(idx * 4);
        e.wd = w;
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], stall);
        chk("we_after_last_byte", 64'(bus.o_we), 64'd1);
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] l);
        bus.i_start = 1'b1;
        bus.i_len   = l;
        tick();
        bus.i_start = 1'b0;
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_len        = 8'd0;
        bus.i_byte_valid = 1'b0;
        bus.i_byte_data  = 8'd0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_byte_ready", 64'(bus.o_byte_ready), 64'd0);
        chk("rst_we", 64'(bus.o_we), 64'd0);
        chk("rst_wa", 64'(bus.o_wa), 64'd0);
        chk("rst_wd", 64'(bus.o_wd), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_err", 64'(bus.o_err), 64'd0);
        chk("rst_core_rst_n", 64'(bus.o_core_rst_n), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("core_rst_n_before_edge", 64'(bus.o_core_rst_n), 64'd0);
        tick();
        chk("core_rst_n_first_edge", 64'(bus.o_core_rst_n), 64'd1);

        // Byte offered in IDLE is ignored
        bus.i_byte_valid = 1'b1;
        bus.i_byte_data  = 8'hAA;
        tick();
        chk("idle_ready", 64'(bus.o_byte_ready), 64'd0);
        chk("idle_busy", 64'(bus.o_busy), 64'd0);
        bus.i_byte_valid = 1'b0;

        // Single word
        do_start(8'd1);
        chk("single_busy", 64'(bus.o_busy), 64'd1);
        chk("single_ready", 64'(bus.o_byte_ready), 64'd1);
        chk("single_core_hold", 64'(bus.o_core_rst_n), 64'd0);
        load_word(0, 32'h0050_0013, 1'b0);
        tick();
        chk("single_we_one_cycle", 64'(bus.o_we), 64'd0);
        chk("single_done", 64'(bus.o_done), 64'd1);
        chk("single_busy_end", 64'(bus.o_busy), 64'd0);
        chk("single_core_release", 64'(bus.o_core_rst_n), 64'd1);
        chk("single_writes", 64'(n_writes), 64'd1);

        // Full depth with random stalls
        w0 = n_writes;
        do_start(8'd128);
        chk("full_done_cleared", 64'(bus.o_done), 64'd0);
        for (int i = 0; i < 128; i++) begin
            word = $urandom;
            load_word(i, word, 1'b1);
        end
        tick();
        chk("full_done", 64'(bus.o_done), 64'd1);
        chk("full_writes", 64'(n_writes - w0), 64'd128);

        // Illegal lengths
        w0 = n_writes;
        do_start(8'd0);
        chk("len0_err", 64'(bus.o_err), 64'd1);
        chk("len0_done", 64'(bus.o_done), 64'd0);
        chk("len0_busy", 64'(bus.o_busy), 64'd0);
        tick();
        do_start(8'd129);
        chk("len129_err", 64'(bus.o_err), 64'd1);
        chk("len129_busy", 64'(bus.o_busy), 64'd0);
        tick();
        chk("illegal_no_we", 64'(n_writes - w0), 64'd0);

        // Start while busy is ignored
        w0 = n_writes;
        do_start(8'd3);
        chk("busy_err_cleared", 64'(bus.o_err), 64'd0);
        load_word(0, 32'hDEAD_BEEF, 1'b0);
        tick();
        do_start(8'd5);
        chk("busy_start_ignored", 64'(bus.o_busy), 64'd1);
        chk("busy_start_no_err", 64'(bus.o_err), 64'd0);
        load_word(1, 32'h1234_5678, 1'b0);
        load_word(2, 32'h0BAD_F00D, 1'b1);
        tick();
        chk("busy_done", 64'(bus.o_done), 64'd1);
        chk("busy_writes", 64'(n_writes - w0), 64'd3);

        // Reset mid-load
        w0 = n_writes;
        do_start(8'd4);
        load_word(0, 32'hCAFE_0001, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        bus.i_byte_valid = 1'b0;
        #3;
        last_wa = '0;
        last_wd = '0;
        rst_n   = 1'b0;
        #1;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        chk("midrst_ready", 64'(bus.o_byte_ready), 64'd0);
        chk("midrst_core", 64'(bus.o_core_rst_n), 64'd0);
        chk("midrst_wa", 64'(bus.o_wa), 64'd0);
        chk("midrst_wd", 64'(bus.o_wd), 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrst_writes", 64'(n_writes - w0), 64'd1);
        do_start(8'd1);
        load_word(0, 32'h0000_0073, 1'b0);
        tick();
        chk("midrst_reload_done", 64'(bus.o_done), 64'd1);

        // Reload from DONE
        w0 = n_writes;
        do_start(8'd2);
        chk("reload_done_clear", 64'(bus.o_done), 64'd0);
        chk("reload_busy", 64'(bus.o_busy), 64'd1);
        load_word(0, 32'hA5A5_0F0F, 1'b0);
        load_word(1, 32'h5A5A_F0F0, 1'b1);
        tick();
        chk("reload_done", 64'(bus.o_done), 64'd1);
        chk("reload_writes", 64'(n_writes - w0), 64'd2);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter INS_ADDRESS, default 9: byte-address width of the instruction memory write port.
REQ-002 Parameter INS_W, default 32: instruction word width; fixed at 32, 4 bytes per word.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 start  input  1: one-cycle request to begin a load.
REQ-006 len  input  8: number of words to load; latched when start is accepted.
REQ-007 byte_valid  input  1: source presents a program byte.
REQ-008 byte_data  input  8: program byte; little-endian within each word.
REQ-009 byte_ready  output  1: loader accepts a byte when byte_valid and byte_ready are both high.
REQ-010 wa  output  INS_ADDRESS: instruction memory write byte address, always word-aligned (wa[1:0]=0).
REQ-011 wd  output  32: instruction memory write data.
REQ-012 we  output  1: instruction memory write enable, one cycle per word.
REQ-013 busy  output  1: a load is in progress.
REQ-014 done  output  1: the last load completed successfully.
REQ-015 err  output  1: the last start was rejected for an illegal len.
REQ-016 core_rst_n  output  1: active-low hold for the RISC-V core; low while busy.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE and DONE; all outputs SHALL be registered.
REQ-018 start SHALL be accepted only in IDLE or DONE; start in RECV or WRITE SHALL be ignored.
REQ-019 On accepted start with 1 <= len <= 2**(INS_ADDRESS-2), the FSM SHALL go to RECV, clear the word index and byte index, clear done and err, and latch len.
REQ-020 On accepted start with len=0 or len > 2**(INS_ADDRESS-2), the FSM SHALL go to IDLE, set err=1, clear done, and perform no write.
REQ-021 In RECV, byte_ready SHALL be 1; each accepted byte SHALL be placed in bits [8*k+7:8*k] of the word buffer, where k is the byte index (0..3).
REQ-022 The byte index SHALL increment on each accepted byte. Accepting byte 3 SHALL wrap the index to 0 and move the FSM to WRITE.
REQ-023 In WRITE, byte_ready SHALL be 0. For exactly one cycle, we=1, wd=the word buffer, and wa = word index times 4, with the upper bits truncated to INS_ADDRESS.
REQ-024 If the 4th byte is accepted on edge N, we SHALL be high in the cycle following edge N.
REQ-025 After WRITE, if word index = len-1 the FSM SHALL go to DONE; otherwise the word index SHALL increment and the FSM SHALL return to RECV.
REQ-026 byte_valid low in RECV SHALL stall the FSM with no state change; bytes offered outside RECV SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in RECV and WRITE. core_rst_n SHALL equal the inverse of busy.
REQ-028 In DONE, done SHALL be 1 and SHALL remain 1 until the next accepted start or reset.
REQ-029 we SHALL never assert outside WRITE. wa and wd SHALL hold their last values when we=0.

Reset
REQ-030 When rst_n is low, the FSM SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-031 Reset values: byte_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, core_rst_n=0, word index=0, byte index=0.
REQ-032 core_rst_n SHALL rise to 1 on the first clock edge after rst_n deasserts.
REQ-033 Reset asserted mid-load SHALL abort the load; any partially assembled word SHALL be discarded and never written.

Verification
REQ-034 Single word: start with len=1, then bytes 0x13,0x00,0x50,0x00 back-to-back -> exactly one write with wa=0 and wd=0x00500013, the write one cycle after the last byte; then done=1, busy=0, core_rst_n=1.
REQ-035 Full depth with stalls: start with len=128, byte_valid randomly deasserted -> 128 writes with wa=0,4,...,508 and data matching the stream; byte_ready=0 during every WRITE cycle.
REQ-036 Illegal length: start with len=0, then start with len=129 -> err=1 after each, no we, busy stays 0.
REQ-037 Start while busy: start with len=5 issued during word 2 of a len=3 load -> ignored; exactly 3 writes occur, then done=1.
REQ-038 Reset mid-load: rst_n pulsed low after 2 bytes of word 1 of a len=4 load -> outputs take reset values immediately and no further we; a fresh start with len=1 then loads correctly at wa=0.
REQ-039 Reload: start with len=2 while in DONE -> done clears on the next edge, busy=1, and the second load overwrites from wa=0.
